// File: rtl/text_console_pkg.sv
// Shared definitions for the text console engine: control codes and FSM encoding.
package text_console_pkg;

   localparam logic [7:0] CC_BS  = 8'h08;
   localparam logic [7:0] CC_TAB = 8'h09;
   localparam logic [7:0] CC_LF  = 8'h0A;
   localparam logic [7:0] CC_FF  = 8'h0C;
   localparam logic [7:0] CC_CR  = 8'h0D;

   typedef logic [1:0] st_t;

   localparam st_t ST_IDLE = 2'd0;
   localparam st_t ST_PUT  = 2'd1;
   localparam st_t ST_CLRL = 2'd2;
   localparam st_t ST_CLRS = 2'd3;

endpackage

// File: rtl/tc_addr_gen.sv
// Logical (row, col) plus ring offset to physical text RAM address.
// Shared with the display-side reader so both sides use one mapping.
module tc_addr_gen #(
   parameter int unsigned COLS = 80,
   parameter int unsigned ROWS = 25,
   parameter int unsigned AW   = 11
) (
   input  logic [5:0]    row,
   input  logic [5:0]    ofs,
   input  logic [7:0]    col,
   output logic [AW-1:0] addr
);

   logic [6:0] sum;
   logic [6:0] prow;

   // Wrap the physical row once (both operands are below ROWS), then linearise.
   always_comb begin
      sum  = {1'b0, row} + {1'b0, ofs};
      prow = (sum >= 7'(ROWS)) ? (sum - 7'(ROWS)) : sum;
      addr = AW'((32'(prow) * 32'(COLS)) + 32'(col));
   end

endmodule

// File: rtl/text_console.sv
// Character-stream console engine: cursor tracking, control-code decode,
// ring-scrolled line clears, full-screen clears and a direct write port.
module text_console
   import text_console_pkg::*;
#(
   parameter int unsigned COLS           = 80,
   parameter int unsigned ROWS           = 25,
   parameter int unsigned AW             = 11,
   parameter int unsigned TABW           = 8,
   parameter logic [7:0]  BLANK          = 8'h00,
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input  logic          clk50,
   input  logic          reset,
   input  logic          ch_valid,
   input  logic [7:0]    ch_data,
   output logic          ch_ready,
   input  logic          dw_valid,
   input  logic [AW-1:0] dw_addr,
   input  logic [7:0]    dw_data,
   output logic          dw_ready,
   output logic          tram_we,
   output logic [AW-1:0] tram_addr,
   output logic [7:0]    tram_din,
   output logic [7:0]    cur_x,
   output logic [5:0]    cur_y,
   output logic [5:0]    row_ofs,
   output logic          busy
);

   localparam int unsigned NCELL = COLS * ROWS;
   localparam int unsigned CW    = $clog2(NCELL);

   st_t           state_q, state_d;
   logic [7:0]    x_q, x_d;
   logic [5:0]    y_q, y_d;
   logic [5:0]    ofs_q, ofs_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] base_q, base_d;
   logic          nl_q, nl_d;
   logic          init_q, init_d;
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [7:0]    din_q, din_d;

   logic [AW-1:0] cur_addr;
   logic [AW-1:0] nl_base;
   logic [5:0]    nl_y;
   logic [5:0]    nl_ofs;
   logic [8:0]    tab_x;
   logic          idle;
   logic          do_line;

   tc_addr_gen #(.COLS(COLS), .ROWS(ROWS), .AW(AW)) u_cur_addr (
      .row  (y_q),
      .ofs  (ofs_q),
      .col  (x_q),
      .addr (cur_addr)
   );

   tc_addr_gen #(.COLS(COLS), .ROWS(ROWS), .AW(AW)) u_nl_addr (
      .row  (nl_y),
      .ofs  (nl_ofs),
      .col  (8'd0),
      .addr (nl_base)
   );

   // Cursor position a newline would produce, and the next tab stop.
   always_comb begin
      if (y_q < 6'(ROWS - 1)) begin
         nl_y   = y_q + 6'd1;
         nl_ofs = ofs_q;
      end else begin
         nl_y   = y_q;
         nl_ofs = (ofs_q == 6'(ROWS - 1)) ? 6'd0 : (ofs_q + 6'd1);
      end
      tab_x = {1'b0, (x_q | 8'(TABW - 1))} + 9'd1;
   end

   // Handshake readiness; a pending power-on clear holds off both ports.
   always_comb begin
      idle     = (state_q == ST_IDLE) && !init_q;
      dw_ready = idle;
      ch_ready = idle && !dw_valid;
   end

   // Next-state decode: accept, decode control codes, sequence writes.
   // A printable in the last column stores its newline in nl_q/base_q so the
   // PUT cycle can chain straight into the line clear.
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      ofs_d   = ofs_q;
      cnt_d   = cnt_q;
      base_d  = base_q;
      nl_d    = nl_q;
      init_d  = init_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      din_d   = din_q;
      do_line = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (init_q) begin
               init_d  = 1'b0;
               state_d = ST_CLRS;
               cnt_d   = '0;
               we_d    = 1'b1;
               addr_d  = '0;
               din_d   = BLANK;
            end else if (dw_valid) begin
               state_d = ST_PUT;
               nl_d    = 1'b0;
               we_d    = 1'b1;
               addr_d  = dw_addr;
               din_d   = dw_data;
            end else if (ch_valid) begin
               if (ch_data >= 8'h20) begin
                  state_d = ST_PUT;
                  we_d    = 1'b1;
                  addr_d  = cur_addr;
                  din_d   = ch_data;
                  if (x_q == 8'(COLS - 1)) begin
                     x_d    = '0;
                     y_d    = nl_y;
                     ofs_d  = nl_ofs;
                     base_d = nl_base;
                     nl_d   = 1'b1;
                  end else begin
                     x_d  = x_q + 8'd1;
                     nl_d = 1'b0;
                  end
               end else begin
                  case (ch_data)
                     CC_BS: begin
                        if (x_q != 8'd0) x_d = x_q - 8'd1;
                     end
                     CC_CR: x_d = '0;
                     CC_LF: do_line = 1'b1;
                     CC_TAB: begin
                        if (tab_x >= 9'(COLS)) do_line = 1'b1;
                        else                   x_d = tab_x[7:0];
                     end
                     CC_FF: begin
                        x_d     = '0;
                        y_d     = '0;
                        ofs_d   = '0;
                        state_d = ST_CLRS;
                        cnt_d   = '0;
                        we_d    = 1'b1;
                        addr_d  = '0;
                        din_d   = BLANK;
                     end
                     default: ;
                  endcase
               end
            end
            if (do_line) begin
               x_d     = '0;
               y_d     = nl_y;
               ofs_d   = nl_ofs;
               base_d  = nl_base;
               state_d = ST_CLRL;
               cnt_d   = '0;
               we_d    = 1'b1;
               addr_d  = nl_base;
               din_d   = BLANK;
            end
         end
         ST_PUT: begin
            if (nl_q) begin
               nl_d    = 1'b0;
               state_d = ST_CLRL;
               cnt_d   = '0;
               we_d    = 1'b1;
               addr_d  = base_q;
               din_d   = BLANK;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CLRL: begin
            if (cnt_q == CW'(COLS - 1)) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d  = cnt_q + CW'(1);
               we_d   = 1'b1;
               addr_d = base_q + AW'(cnt_q) + AW'(1);
               din_d  = BLANK;
            end
         end
         ST_CLRS: begin
            if (cnt_q == CW'(NCELL - 1)) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d  = cnt_q + CW'(1);
               we_d   = 1'b1;
               addr_d = AW'(cnt_q) + AW'(1);
               din_d  = BLANK;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers; reset aborts any write sequence immediately.
   always_ff @(posedge clk50 or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         ofs_q   <= '0;
         cnt_q   <= '0;
         base_q  <= '0;
         nl_q    <= 1'b0;
         init_q  <= CLEAR_ON_RESET;
         we_q    <= 1'b0;
         addr_q  <= '0;
         din_q   <= BLANK;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         ofs_q   <= ofs_d;
         cnt_q   <= cnt_d;
         base_q  <= base_d;
         nl_q    <= nl_d;
         init_q  <= init_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
      end
   end

   assign tram_we   = we_q;
   assign tram_addr = addr_q;
   assign tram_din  = din_q;
   assign cur_x     = x_q;
   assign cur_y     = y_q;
   assign row_ofs   = ofs_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_text_console.sv
// Randomised bench for text_console against a cell-level console model.
module tb_text_console;

   localparam int unsigned COLS  = 80;
   localparam int unsigned ROWS  = 25;
   localparam int unsigned AW    = 11;
   localparam int unsigned TABW  = 8;
   localparam logic [7:0]  BLANK = 8'h00;

   typedef struct {
      logic [AW-1:0] a;
      logic [7:0]    d;
   } wr_t;

   logic          clk;
   logic          reset;
   logic          ch_valid;
   logic [7:0]    ch_data;
   logic          ch_ready;
   logic          dw_valid;
   logic [AW-1:0] dw_addr;
   logic [7:0]    dw_data;
   logic          dw_ready;
   logic          tram_we;
   logic [AW-1:0] tram_addr;
   logic [7:0]    tram_din;
   logic [7:0]    cur_x;
   logic [5:0]    cur_y;
   logic [5:0]    row_ofs;
   logic          busy;

   int  tests = 0;
   int  fails = 0;
   wr_t exp_q[$];
   int  mx, my, mofs;
   int  wr_count;
   int  last_a, last_d;
   bit  chk_en = 1'b0;

   text_console #(
      .COLS(COLS), .ROWS(ROWS), .AW(AW), .TABW(TABW),
      .BLANK(BLANK), .CLEAR_ON_RESET(1'b1)
   ) dut (
      .clk50(clk), .reset(reset),
      .ch_valid(ch_valid), .ch_data(ch_data), .ch_ready(ch_ready),
      .dw_valid(dw_valid), .dw_addr(dw_addr), .dw_data(dw_data), .dw_ready(dw_ready),
      .tram_we(tram_we), .tram_addr(tram_addr), .tram_din(tram_din),
      .cur_x(cur_x), .cur_y(cur_y), .row_ofs(row_ofs), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic int maddr(input int x, input int y, input int o);
      return ((y + o) % ROWS) * COLS + x;
   endfunction

   task automatic m_push(input int a, input logic [7:0] d);
      wr_t w;
      w.a = AW'(a);
      w.d = d;
      exp_q.push_back(w);
   endtask

   task automatic m_newline();
      mx = 0;
      if (my < ROWS - 1) my++;
      else mofs = (mofs + 1) % ROWS;
      for (int i = 0; i < COLS; i++) m_push(maddr(i, my, mofs), BLANK);
   endtask

   task automatic m_char(input logic [7:0] b);
      int t;
      if (b >= 8'h20) begin
         m_push(maddr(mx, my, mofs), b);
         if (mx == COLS - 1) m_newline();
         else mx++;
      end else if (b == 8'h08) begin
         if (mx > 0) mx--;
      end else if (b == 8'h0D) begin
         mx = 0;
      end else if (b == 8'h0A) begin
         m_newline();
      end else if (b == 8'h09) begin
         t = (mx / TABW + 1) * TABW;
         if (t >= COLS) m_newline();
         else mx = t;
      end else if (b == 8'h0C) begin
         mx = 0; my = 0; mofs = 0;
         for (int i = 0; i < COLS * ROWS; i++) m_push(i, BLANK);
      end
   endtask

   // ---------------- per-cycle compare ----------------
   always @(posedge clk) begin
      int  qs;
      wr_t w;
      #2;
      if (chk_en) begin
         qs = exp_q.size();
         chk("busy", busy, int'(qs > 0));
         chk("dw_ready", dw_ready, int'(qs == 0));
         chk("ch_ready", ch_ready, int'(qs == 0 && !dw_valid));
         chk("tram_we", tram_we, int'(qs > 0));
         if (tram_we && qs > 0) begin
            w = exp_q.pop_front();
            chk("tram_addr", tram_addr, w.a);
            chk("tram_din", tram_din, w.d);
            last_a = tram_addr;
            last_d = tram_din;
            wr_count++;
         end
         chk("cur_x", cur_x, mx);
         chk("cur_y", cur_y, my);
         chk("row_ofs", row_ofs, mofs);
      end
   end

   // ---------------- stimulus helpers (entered at a negedge) ----------------
   task automatic release_reset();
      exp_q.delete();
      mx = 0; my = 0; mofs = 0;
      wr_count = 0;
      for (int i = 0; i < COLS * ROWS; i++) m_push(i, BLANK);
      reset  = 1'b0;
      chk_en = 1'b1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (exp_q.size() != 0 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 5000) chk("idle_timeout", n, 0);
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic xfer(input bit dv, input int da, input logic [7:0] dd,
                       input bit cv, input logic [7:0] cd);
      int n  = 0;
      bit dp = dv;
      bit cp = cv;
      dw_valid = dv; dw_addr = AW'(da); dw_data = dd;
      ch_valid = cv; ch_data = cd;
      while (dp || cp) begin
         #2;
         if (dp && cp) chk("ch_blocked_by_dw", ch_ready, 0);
         if (dp && dw_ready) begin
            m_push(da % (1 << AW), dd);
            dp = 1'b0;
         end else if (cp && ch_ready) begin
            m_char(cd);
            cp = 1'b0;
         end
         @(negedge clk);
         dw_valid = dp;
         ch_valid = cp;
         n++;
         if (n > 5000) begin
            chk("xfer_timeout", n, 0);
            dp = 1'b0; cp = 1'b0;
            dw_valid = 1'b0; ch_valid = 1'b0;
         end
      end
   endtask

   task automatic send(input logic [7:0] b);
      xfer(1'b0, 0, 8'h00, 1'b1, b);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int n;
      int r;
      int ffn = 0;
      logic [7:0] b;
      reset = 1'b1; ch_valid = 1'b0; ch_data = '0;
      dw_valid = 1'b0; dw_addr = '0; dw_data = '0;
      #1;
      chk("rst_we", tram_we, 0);
      chk("rst_din", tram_din, BLANK);
      chk("rst_busy", busy, 0);
      chk("rst_x", cur_x, 0);
      repeat (3) @(negedge clk);
      release_reset();
      wait_idle();
      chk("init_writes", wr_count, 2000);
      chk("init_ch_ready", ch_ready, 1);

      send(8'h41); send(8'h42);
      wait_idle();
      chk("ab_x", cur_x, 2);
      chk("ab_last_a", last_a, 1);
      chk("ab_last_d", last_d, 8'h42);
      n = wr_count;
      repeat (3) send(8'h08);
      wait_idle();
      chk("bs_x", cur_x, 0);
      chk("bs_nowrite", wr_count, n);

      for (int i = 0; i < 81; i++) send(8'h61 + 8'(i % 26));
      wait_idle();
      chk("wrap_y", cur_y, 1);
      chk("wrap_x", cur_x, 1);
      chk("wrap_last_a", last_a, 80);
      chk("wrap_last_d", last_d, 8'h63);

      send(8'h0C);
      wait_idle();
      repeat (25) send(8'h0A);
      wait_idle();
      chk("lf_ofs", row_ofs, 1);
      chk("lf_y", cur_y, 24);
      chk("lf_clr_last_a", last_a, 79);
      repeat (24) send(8'h0A);
      wait_idle();
      chk("lf_ofs_wrap", row_ofs, 0);

      send(8'h0D);
      repeat (77) send(8'h2E);
      wait_idle();
      chk("tab_pre_x", cur_x, 77);
      send(8'h09);
      wait_idle();
      chk("tab_nl_x", cur_x, 0);
      chk("tab_nl_ofs", row_ofs, 1);
      send(8'h0D);
      repeat (3) send(8'h2D);
      wait_idle();
      n = wr_count;
      send(8'h09);
      wait_idle();
      chk("tab_x", cur_x, 8);
      chk("tab_nowrite", wr_count, n);

      xfer(1'b1, 5, 8'h55, 1'b1, 8'h5A);
      wait_idle();
      chk("both_last_d", last_d, 8'h5A);

      for (int k = 0; k < 300; k++) begin
         r = $urandom_range(0, 99);
         if (r < 5) @(negedge clk);
         else if (r < 12) xfer(1'b1, $urandom_range(0, 2047), 8'($urandom), 1'b0, 8'h00);
         else if (r < 15) xfer(1'b1, $urandom_range(0, 2047), 8'($urandom), 1'b1, 8'($urandom_range(32, 255)));
         else if (r < 60) send(8'($urandom_range(32, 255)));
         else if (r < 67) send(8'h08);
         else if (r < 72) send(8'h0D);
         else if (r < 79) send(8'h0A);
         else if (r < 87) send(8'h09);
         else if (r < 95) begin
            b = 8'($urandom_range(0, 31));
            if (b == 8'h08 || b == 8'h09 || b == 8'h0A || b == 8'h0C || b == 8'h0D) b = 8'h1B;
            send(b);
         end else if (ffn < 2) begin
            send(8'h0C);
            ffn++;
         end else send(8'($urandom_range(32, 255)));
      end
      wait_idle();

      send(8'h0C);
      repeat (100) @(negedge clk);
      #4;
      chk_en = 1'b0;
      reset  = 1'b1;
      #1;
      chk("midclr_we", tram_we, 0);
      chk("midclr_busy", busy, 0);
      chk("midclr_addr", tram_addr, 0);
      chk("midclr_din", tram_din, BLANK);
      @(negedge clk);
      @(negedge clk);
      release_reset();
      wait_idle();
      chk("reinit_writes", wr_count, 2000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/text_console.md
# text_console

Parametrised character-stream console engine for the VGA text plane: it consumes a byte stream from the CPU I/O decoder, keeps the cursor and a ring-buffer row offset, and drives the write port of the text buffer RAM. It adds to the existing fixed 80x25 text-write logic:
- configurable geometry;
- CR, TAB and form-feed handling;
- a bounded backspace;
- multi-cycle line and screen clears;
- a prioritised direct-address write port.

The display side reads `row_ofs` to scroll without copying RAM.

## Interface
- `COLS`, 80, characters per row (2..255)
- `ROWS`, 25, rows per screen (2..63)
- `AW`, 11, text RAM address width; must satisfy 2^AW >= COLS*ROWS
- `TABW`, 8, tab stop spacing, power of two
- `BLANK`, 8'h00, fill byte for clears
- `CLEAR_ON_RESET`, 1, run a full-screen clear after reset release
- `clk50` in 1 — system clock
- `reset` in 1 — asynchronous, active-high
- `ch_valid` in 1 — stream byte offered
- `ch_data` in 8 — stream byte
- `ch_ready` out 1 — stream byte accepted when `ch_valid && ch_ready`
- `dw_valid` in 1 — direct write request
- `dw_addr` in AW — physical RAM address
- `dw_data` in 8 — direct write byte
- `dw_ready` out 1 — direct write accepted when `dw_valid && dw_ready`
- `tram_we` out 1 — RAM write strobe
- `tram_addr` out AW — RAM write address
- `tram_din` out 8 — RAM write data
- `cur_x` out 8 — cursor column, 0..COLS-1
- `cur_y` out 6 — cursor logical row, 0..ROWS-1
- `row_ofs` out 6 — physical row shown as logical row 0
- `busy` out 1 — engine not IDLE

## Operation
- States:
  - IDLE;
  - PUT: one write;
  - CLRL: clear one line, COLS writes;
  - CLRS: clear screen, COLS*ROWS writes.
- Readiness:
  - `dw_ready` = IDLE.
  - `ch_ready` = IDLE && !dw_valid. A direct write always wins over a simultaneous stream byte.
- Physical row prow = cur_y+row_ofs, minus ROWS if the sum is >= ROWS. Address = prow*COLS+cur_x.
- Direct write: IDLE→PUT with address `dw_addr`, data `dw_data`. Cursor is unchanged.
- Stream byte decode:
  - >= 8'h20: PUT at the cursor. Then cursor x+1. If x was COLS-1, perform a newline after the PUT.
  - 8'h08 BS: x-1 if x>0, else no change. No write; x never underflows.
  - 8'h0D CR: x=0, no write.
  - 8'h0A LF: newline.
  - 8'h09 TAB: x = (x|(TABW-1))+1. If the result is >= COLS, perform a newline.
  - 8'h0C FF: x=y=row_ofs=0, then CLRS.
  - Other control bytes: accepted, no effect.
- Newline:
  - x=0.
  - If y<ROWS-1: y+1.
  - Else: y stays, row_ofs+1 wrapping ROWS-1→0.
  - Then CLRL on the new cursor line's physical row.
- CLRL writes addresses prow*COLS+0..COLS-1 with `BLANK`, then returns to IDLE.
- CLRS writes addresses 0..COLS*ROWS-1 with `BLANK`, then returns to IDLE.
- Reset values:
  - all outputs 0; `tram_din` = `BLANK`; state IDLE;
  - if CLEAR_ON_RESET, the first cycle after reset deasserts enters CLRS with `busy`=1.
- Reset asserted mid-clear or mid-PUT aborts immediately: `tram_we`=0 asynchronously, with the reset values above. No partial state survives.

## Timing
- All outputs are registered.
- Accept in cycle N → `tram_we`=1 in cycle N+1 with address and data valid.
- Cursor, `row_ofs` and state update at the same N+1 edge.
- Printable byte without wrap:
  - one write cycle; `ch_ready` is low in N+1;
  - the next accept is possible in N+2.
- Newline with no preceding printable: writes in N+1..N+COLS, `ch_ready` high again at N+COLS+1.
- Printable in the last column: one PUT cycle plus COLS clear cycles, COLS+1 write cycles in total.
- FF: COLS*ROWS consecutive write cycles.
- BS, CR and ignored bytes: no write. `ch_ready` returns high in N+1, giving back-to-back acceptance.
- `tram_we` is never asserted while the engine is in IDLE.

## Structure
- Shared package `text_console_pkg`:
  - control-code constants `CC_BS`, `CC_TAB`, `CC_LF`, `CC_FF`, `CC_CR`;
  - state encoding `st_t`.
- One sub-module `tc_addr_gen` (combinational): prow wrap and prow*COLS+col. Also instantiated by the display-side reader so read and write mapping cannot diverge.
- Clear counter width: clog2(COLS*ROWS).

## Test plan
- Reset, CLEAR_ON_RESET=1, COLS=80, ROWS=25 → exactly 2000 writes of 8'h00 to addresses 0..1999, then `busy`=0, `ch_ready`=1.
- Send 'A','B' at the origin → writes 8'h41@0, 8'h42@1; `cur_x`=2. BS×3 → `cur_x`=0, no writes.
- 81 printable bytes from the origin → byte 80 written at 79; line 1 cleared at 80..159; byte 81 written at 80; `cur_y`=1.
- 25 LFs from y=0 → last LF gives `row_ofs`=1, `cur_y`=24, clear of physical row 0 at addresses 0..79. 24 more LFs → `row_ofs` wraps to 0.
- TAB at x=77, COLS=80, TABW=8 → newline, `cur_x`=0. TAB at x=3 → `cur_x`=8, no write.
- `dw_valid` and `ch_valid` asserted in the same IDLE cycle → direct write performed first, stream byte accepted after it. Reset pulse during CLRS → `tram_we`=0 immediately.
